// File: rtl/vmem_fb_clear.sv
// Video frame-buffer RAM: registered read port, write port, and a clear engine
// that fills one word per cycle. Define VMEM_BYPASS_EN for write-first reads.
module vmem_fb_clear #(
  parameter int                DATA_W = 24,
  parameter int                ADDR_W = 13,
  parameter int                DEPTH  = 8192,
  parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  input  logic [DATA_W-1:0] clr_fill,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] clr_val, clr_val_nxt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_hit, wr_hit;

  assign rd_hit = ({1'b0, rd_addr} < DEPTH_X);
  assign wr_hit = ({1'b0, wr_addr} < DEPTH_X);
  assign busy   = (state == CLEAR);

  // The single memory write port is shared: the clear engine owns it while
  // busy, otherwise in-range external writes go through.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_val_nxt = clr_val;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
    case (state)
      IDLE: begin
        mem_we = wr_en && wr_hit;
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
          clr_val_nxt = clr_fill;
        end
      end
      CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_cnt;
        mem_wdata   = clr_val;
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_cnt == LAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      clr_val  <= FILL;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      clr_val  <= clr_val_nxt;
      clr_done <= (state == CLEAR) && (clr_cnt == LAST);
      wr_drop  <= (state == CLEAR) && wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
    end
  end

  // Out-of-range reads return zero rather than aliasing onto a real word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (!rd_hit) begin
          rd_data <= '0;
        end
`ifdef VMEM_BYPASS_EN
        else if (mem_we && (mem_waddr == rd_addr)) begin
          rd_data <= mem_wdata;
        end
`endif
        else begin
          rd_data <= mem[rd_addr[IDX_W-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_vmem_fb_clear.sv
// Scoreboard bench for vmem_fb_clear at DEPTH=16: read expectations are queued
// at issue time and popped by a monitor whenever rd_valid is seen.
module tb_vmem_fb_clear;

  localparam int                DATA_W = 24;
  localparam int                ADDR_W = 5;
  localparam int                DEPTH  = 16;
  localparam logic [DATA_W-1:0] FILL   = 24'h112233;

  logic              clk;
  logic              rst_n;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic [DATA_W-1:0] clr_fill;
  logic              busy;
  logic              clr_done;
  logic              wr_drop;

  int n_vec  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  logic [DATA_W-1:0] exp_q [$];

  vmem_fb_clear #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .FILL  (FILL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_req (clr_req),
    .clr_fill(clr_fill),
    .busy    (busy),
    .clr_done(clr_done),
    .wr_drop (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; a read pushes its expected data for the monitor.
  task automatic applyStimulus(input logic re, input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] rexp,
                               input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input logic cr, input logic [DATA_W-1:0] cf);
    rd_en    = re;
    rd_addr  = ra;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    clr_req  = cr;
    clr_fill = cf;
    if (re) exp_q.push_back(rexp);
    @(posedge clk);
    #1;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  task automatic readAll(input logic [DATA_W-1:0] exp);
    for (int a = 0; a < DEPTH; a++) applyStimulus(1, ADDR_W'(a), exp, 0, '0, '0, 0, '0);
  endtask

  // Counts sampled cycles with busy high (bounded), then checks the done pulse.
  task automatic waitClear(input string name, input int exp_cycles);
    int cycles = 0;
    while (busy === 1'b1 && cycles < 64) begin
      cycles++;
      @(posedge clk);
      #1;
    end
    checkOutput({name, " busy cycles"}, cycles, exp_cycles);
    checkOutput({name, " clr_done pulse"}, {31'b0, clr_done}, 1);
    @(posedge clk);
    #1;
    checkOutput({name, " clr_done one cycle"}, {31'b0, clr_done}, 0);
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious rd_valid", {31'b0, rd_valid}, 0);
      end else begin
        checkOutput("rd_data", {8'b0, rd_data}, {8'b0, exp_q.pop_front()});
      end
    end
    if (rst_n === 1'b1 && clr_done === 1'b1) done_cnt++;
    if (rst_n === 1'b1 && wr_drop === 1'b1) drop_cnt++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [DATA_W-1:0] same_exp;
    logic [DATA_W-1:0] clr_coll_exp;
    int drops_before;
`ifdef VMEM_BYPASS_EN
    same_exp     = 24'h000002;
    clr_coll_exp = 24'h0000BB;
`else
    same_exp     = 24'h000001;
    clr_coll_exp = 24'h112233;
`endif
    rst_n = 1'b0; rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0;
    wr_data = '0; clr_req = 0; clr_fill = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'b0, busy}, 1);
    checkOutput("reset rd_valid", {31'b0, rd_valid}, 0);
    checkOutput("reset rd_data", {8'b0, rd_data}, 0);
    checkOutput("reset clr_done", {31'b0, clr_done}, 0);
    checkOutput("reset wr_drop", {31'b0, wr_drop}, 0);

    $display("[TB] post-reset clear");
    rst_n = 1'b1;
    waitClear("post-reset", 16);
    readAll(FILL);

    $display("[TB] write/read in IDLE");
    applyStimulus(0, '0, '0, 1, 5'd5, 24'hABCDEF, 0, '0);
    applyStimulus(0, '0, '0, 1, 5'd20, 24'hDEAD00, 0, '0);
    applyStimulus(1, 5'd20, 24'h000000, 0, '0, '0, 0, '0);
    applyStimulus(1, 5'd4, FILL, 0, '0, '0, 0, '0);
    applyStimulus(1, 5'd5, 24'hABCDEF, 0, '0, '0, 0, '0);
    applyStimulus(0, '0, '0, 0, '0, '0, 0, '0);
    checkOutput("rd_valid low without rd_en", {31'b0, rd_valid}, 0);
    checkOutput("rd_data holds", {8'b0, rd_data}, {8'b0, 24'hABCDEF});
    checkOutput("no drop for out-of-range write", drop_cnt, 0);

    $display("[TB] requested clear with write collision");
    applyStimulus(0, '0, '0, 1, 5'd3, 24'h123456, 1, 24'h00FF00);
    checkOutput("busy after clr_req", {31'b0, busy}, 1);
    applyStimulus(1, 5'd3, 24'h123456, 1, 5'd7, 24'h777777, 0, '0);
    applyStimulus(0, '0, '0, 1, 5'd8, 24'h888888, 0, '0);
    waitClear("collision", 14);
    checkOutput("dropped writes", drop_cnt, 2);
    applyStimulus(1, 5'd3, 24'h00FF00, 0, '0, '0, 0, '0);
    applyStimulus(1, 5'd5, 24'h00FF00, 0, '0, '0, 0, '0);
    applyStimulus(1, 5'd7, 24'h00FF00, 0, '0, '0, 0, '0);
    applyStimulus(1, 5'd8, 24'h00FF00, 0, '0, '0, 0, '0);

    $display("[TB] reset mid-clear");
    applyStimulus(0, '0, '0, 0, '0, '0, 1, 24'hFFFFFF);
    idle(7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("busy in mid-clear reset", {31'b0, busy}, 1);
    @(posedge clk);
    #1;
    checkOutput("busy held in reset", {31'b0, busy}, 1);
    checkOutput("rd_valid in reset", {31'b0, rd_valid}, 0);
    rst_n = 1'b1;
    waitClear("restart", 16);
    readAll(FILL);

    $display("[TB] same-address read and write");
    applyStimulus(0, '0, '0, 1, 5'd9, 24'h000001, 0, '0);
    applyStimulus(1, 5'd9, same_exp, 1, 5'd9, 24'h000002, 0, '0);
    applyStimulus(1, 5'd9, 24'h000002, 0, '0, '0, 0, '0);

    $display("[TB] clr_req ignored while busy");
    drops_before = drop_cnt;
    applyStimulus(0, '0, '0, 0, '0, '0, 1, 24'h0000BB);
    applyStimulus(1, 5'd0, clr_coll_exp, 0, '0, '0, 1, 24'h0000AA);
    applyStimulus(0, '0, '0, 0, '0, '0, 1, 24'h0000AA);
    waitClear("ignore", 14);
    idle(3);
    checkOutput("single clr_done total", done_cnt, 4);
    checkOutput("no drops in ignore test", drop_cnt, drops_before);
    readAll(24'h0000BB);

    idle(2);
    checkOutput("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vmem_fb_clear.md
# vmem_fb_clear

Parametrised single-clock video frame-buffer memory with one synchronous read port, one write port and a built-in clear engine. After reset, and again on request, the clear engine fills every word with a fill colour at one word per cycle. It is the next-generation replacement for the fixed 8192x24 video memory between the pixel writer and the display scan-out logic. It adds reset, read-valid signalling, range checking and in-place frame clearing.

## Interface
- DATA_W, 24: pixel word width in bits.
- ADDR_W, 13: address width in bits.
- DEPTH, 8192: number of words. Must satisfy 2 <= DEPTH <= 2**ADDR_W.
- FILL, {DATA_W{1'b0}}: fill colour used by the clear that runs after reset.

- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data, registered.
- rd_valid  out  1  rd_data carries the result of a request from the previous cycle.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clr_req  in  1  start a clear using clr_fill.
- clr_fill  in  DATA_W  fill colour, sampled together with clr_req.
- busy  out  1  clear engine active; external writes are not accepted.
- clr_done  out  1  one-cycle pulse when a clear completes.
- wr_drop  out  1  one-cycle pulse: an external write was discarded.

## Operation
- State machine states: IDLE and CLEAR. A clear counter clr_cnt (ADDR_W bits) and a fill register clr_val (DATA_W bits) support it.
- Reset (rst_n low at an edge):
  - State becomes CLEAR, clr_cnt = 0, clr_val = FILL.
  - Outputs: busy = 1, rd_data = 0, rd_valid = 0, clr_done = 0, wr_drop = 0.
  - No memory write occurs while rst_n is low.
  - Reset mid-clear restarts the clear from address 0 using FILL.
- IDLE:
  - wr_en with wr_addr < DEPTH writes mem[wr_addr] = wr_data.
  - clr_req latches clr_fill into clr_val, sets clr_cnt = 0 and moves to CLEAR.
  - A wr_en in the same cycle as clr_req is still performed. The clear overwrites it later.
- CLEAR:
  - Each cycle writes mem[clr_cnt] = clr_val and increments clr_cnt.
  - The cycle that writes address DEPTH-1 returns the state to IDLE. clr_done pulses and busy drops after that edge.
  - clr_req is ignored while in CLEAR.
  - Any wr_en is discarded and pulses wr_drop in the following cycle.
- Reads are served in both states:
  - rd_en with rd_addr < DEPTH loads rd_data = mem[rd_addr].
  - rd_en with rd_addr >= DEPTH loads rd_data = 0.
  - rd_valid is rd_en delayed one cycle.
  - Without rd_en, rd_data holds its previous value.
- Out-of-range writes (wr_addr >= DEPTH) in IDLE are silently ignored. They do not pulse wr_drop.
- Read and write to the same address in the same cycle returns the old data (read-first), unless bypass is compiled in (see Configuration). This applies to clear writes as well as external writes.

## Timing
- Read latency is 1 cycle: request at edge t, data and rd_valid after edge t. A new read is accepted every cycle.
- Write latency is 1 cycle: data written at edge t is visible to a read requested at edge t+1.
- Clear from request:
  - clr_req sampled at edge t: busy = 1 after edge t.
  - Address k is written at edge t+1+k.
  - busy falls and clr_done = 1 after edge t+DEPTH, for one cycle.
  - busy is high for exactly DEPTH cycles.
- Clear after reset: the first edge with rst_n high writes address 0. busy falls DEPTH edges later.
- clr_done and wr_drop are registered pulses, never held longer than one cycle.

## Configuration
- VMEM_BYPASS_EN defined:
  - Same-address read and write in the same cycle returns the data being written (write-first).
  - This covers both external writes and clear-engine writes.
  - It adds one comparator and a DATA_W-bit mux ahead of the rd_data register.
- VMEM_BYPASS_EN undefined: read-first behaviour; the memory infers as a plain synchronous RAM.

## Test plan
- Post-reset clear (DEPTH=16, FILL=24'h112233): release rst_n -> busy high for exactly 16 cycles, then one clr_done pulse; reads of addresses 0..15 all return 24'h112233 with rd_valid one cycle after each rd_en.
- Write then read in IDLE: write 24'hABCDEF to address 5, read address 5 on the next cycle -> rd_data = 24'hABCDEF one cycle later; an out-of-range read (address 20 when DEPTH=16) -> rd_data = 0 with rd_valid = 1.
- Requested clear with write collision: clr_req with clr_fill = 24'h00FF00 in the same cycle as a write of 24'h123456 to address 3, then wr_en during busy -> one wr_drop pulse per dropped write; after clr_done, address 3 reads 24'h00FF00.
- Reset mid-clear: drive rst_n low at clear step 7 of a clear started with clr_fill = 24'hFFFFFF -> busy stays high; the clear restarts at address 0 with FILL and takes 16 cycles after rst_n rises; all words read FILL afterwards.
- Same-address read and write: address 9 holds 24'h000001; write 24'h000002 to it and read it in the same cycle -> rd_data = 24'h000001 without VMEM_BYPASS_EN, 24'h000002 with it.
- clr_req ignored while busy: issue clr_req with 24'h0000AA during a clear using 24'h0000BB -> only one clr_done pulse occurs; all words read 24'h0000BB.
